// File: rtl/fifo_sched_rr_if.sv
// fifo_sched_rr_if: FIFO-side bundle of the switch scheduler.
// The master side is the scheduler (pops input FIFOs, pushes output FIFOs);
// the slave side is the FIFO array (or a bench modelling it).
interface fifo_sched_rr_if #(
  parameter int DATA_W = 10
);
  logic [3:0]        in_empty;
  logic [DATA_W-1:0] in_data0;
  logic [DATA_W-1:0] in_data1;
  logic [DATA_W-1:0] in_data2;
  logic [DATA_W-1:0] in_data3;
  logic [3:0]        out_almost_full;
  logic [3:0]        pop_in;
  logic [3:0]        push_out;
  logic [DATA_W-1:0] data_out;

  modport master (
    input  in_empty, in_data0, in_data1, in_data2, in_data3, out_almost_full,
    output pop_in, push_out, data_out
  );

  modport slave (
    output in_empty, in_data0, in_data1, in_data2, in_data3, out_almost_full,
    input  pop_in, push_out, data_out
  );
endinterface

// File: rtl/fifo_sched_rr.sv
// fifo_sched_rr: moves one head word per cycle from four input FIFOs to the
// output FIFO selected by the word's class bits, skipping almost-full
// destinations. Also owns the threshold configuration and per-destination
// word counters.
// Build option: define FSCHED_RR_EN for round-robin arbitration; without it
// the arbiter is fixed priority (input 0 highest) and has no rotating pointer.
module fifo_sched_rr #(
  parameter int DATA_W = 10,
  parameter int THR_W  = 3,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [THR_W-1:0]  limit_low,
  input  logic [THR_W-1:0]  limit_high,
  fifo_sched_rr_if.master   bus,
  output logic [THR_W-1:0]  cfg_low,
  output logic [THR_W-1:0]  cfg_high,
  input  logic              req,
  input  logic [1:0]        idx,
  output logic [CNT_W-1:0]  count_data,
  output logic              count_valid,
  output logic [1:0]        state,
  output logic              idle
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t            state_r;
  logic              idle_r;
  logic [THR_W-1:0]  cfg_low_r;
  logic [THR_W-1:0]  cfg_high_r;
  logic [3:0]        push_r;
  logic [DATA_W-1:0] data_r;
  logic [CNT_W-1:0]  count_data_r;
  logic              count_valid_r;
  logic [CNT_W-1:0]  cnt_r [4];
`ifdef FSCHED_RR_EN
  logic [1:0]        rr_ptr_r;
`endif

  logic [DATA_W-1:0] head_s [4];
  logic [1:0]        dest_s [4];
  logic [3:0]        elig_s;
  logic [1:0]        base_s;
  logic [1:0]        cand_s;
  logic              win_valid_s;
  logic [1:0]        win_s;
  logic [1:0]        win_dest_s;
  logic              pop_go_s;
  logic [3:0]        pop_s;

  // Gather head words and decide which inputs may move this cycle.
  always_comb begin
    head_s[0] = bus.in_data0;
    head_s[1] = bus.in_data1;
    head_s[2] = bus.in_data2;
    head_s[3] = bus.in_data3;
    for (int i = 0; i < 4; i++) begin
      dest_s[i] = head_s[i][DATA_W-1:DATA_W-2];
      elig_s[i] = !bus.in_empty[i] && !bus.out_almost_full[dest_s[i]];
    end
  end

  // Pick the first eligible input scanning upward from the start point.
  always_comb begin
`ifdef FSCHED_RR_EN
    base_s = rr_ptr_r;
`else
    base_s = 2'd0;
`endif
    win_valid_s = 1'b0;
    win_s       = 2'd0;
    cand_s      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand_s = base_s + 2'(k);
      if (!win_valid_s && elig_s[cand_s]) begin
        win_valid_s = 1'b1;
        win_s       = cand_s;
      end else begin
        win_valid_s = win_valid_s;
      end
    end
    win_dest_s = dest_s[win_s];
    // init steals the cycle: nothing moves while leaving ACTIVE for INIT.
    pop_go_s = (state_r == ST_ACTIVE) && !init && win_valid_s;
    if (pop_go_s) begin
      pop_s = 4'b0001 << win_s;
    end else begin
      pop_s = 4'b0000;
    end
  end

  assign bus.pop_in   = pop_s;
  assign bus.push_out = push_r;
  assign bus.data_out = data_r;
  assign cfg_low      = cfg_low_r;
  assign cfg_high     = cfg_high_r;
  assign count_data   = count_data_r;
  assign count_valid  = count_valid_r;
  assign state        = state_r;
  assign idle         = idle_r;

  // Control FSM, datapath register, configuration and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_RESET;
      idle_r        <= 1'b0;
      cfg_low_r     <= THR_W'(1);
      cfg_high_r    <= THR_W'(6);
      push_r        <= 4'b0000;
      data_r        <= {DATA_W{1'b0}};
      count_data_r  <= {CNT_W{1'b0}};
      count_valid_r <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_r[i] <= {CNT_W{1'b0}};
`ifdef FSCHED_RR_EN
      rr_ptr_r      <= 2'd0;
`endif
    end else begin
      // The popped word lands in its output FIFO one cycle later.
      push_r <= pop_go_s ? (4'b0001 << win_dest_s) : 4'b0000;
      if (pop_go_s) begin
        data_r <= head_s[win_s];
      end else begin
        data_r <= data_r;
      end

      // Counter reads sample the value before any same-cycle increment.
      if (req && ((state_r == ST_IDLE) || (state_r == ST_ACTIVE))) begin
        count_valid_r <= 1'b1;
        count_data_r  <= cnt_r[idx];
      end else begin
        count_valid_r <= 1'b0;
        count_data_r  <= {CNT_W{1'b0}};
      end

      case (state_r)
        ST_RESET: begin
          state_r <= ST_INIT;
          idle_r  <= 1'b0;
        end
        ST_INIT: begin
          if (limit_low < limit_high) begin
            cfg_low_r  <= limit_low;
            cfg_high_r <= limit_high;
          end else begin
            cfg_low_r  <= cfg_low_r;
            cfg_high_r <= cfg_high_r;
          end
          for (int i = 0; i < 4; i++) cnt_r[i] <= {CNT_W{1'b0}};
          if (!init) begin
            state_r <= ST_IDLE;
            idle_r  <= 1'b1;
          end else begin
            state_r <= ST_INIT;
            idle_r  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (init) begin
            state_r <= ST_INIT;
            idle_r  <= 1'b0;
          end else if (bus.in_empty != 4'b1111) begin
            state_r <= ST_ACTIVE;
            idle_r  <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            idle_r  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (pop_go_s) begin
            cnt_r[win_dest_s] <= cnt_r[win_dest_s] + CNT_W'(1);
`ifdef FSCHED_RR_EN
            rr_ptr_r <= win_s + 2'd1;
`endif
          end else begin
            cnt_r[win_dest_s] <= cnt_r[win_dest_s];
          end
          if (init) begin
            state_r <= ST_INIT;
            idle_r  <= 1'b0;
          end else if (bus.in_empty == 4'b1111) begin
            state_r <= ST_IDLE;
            idle_r  <= 1'b1;
          end else begin
            state_r <= ST_ACTIVE;
            idle_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_RESET;
          idle_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sched_rr.sv
// tb_fifo_sched_rr: directed bench for fifo_sched_rr. Input FIFOs are
// modelled as first-word-fall-through queues popped by the DUT's pop_in.
module tb_fifo_sched_rr;
  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [2:0] limit_low, limit_high;
  logic [2:0] cfg_low, cfg_high;
  logic       req;
  logic [1:0] idx;
  logic [4:0] count_data;
  logic       count_valid;
  logic [1:0] state;
  logic       idle;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0] q0[$], q1[$], q2[$], q3[$];

  fifo_sched_rr_if #(.DATA_W(10)) ifc ();

  fifo_sched_rr #(.DATA_W(10), .THR_W(3), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .init(init),
    .limit_low(limit_low), .limit_high(limit_high),
    .bus(ifc), .cfg_low(cfg_low), .cfg_high(cfg_high),
    .req(req), .idx(idx), .count_data(count_data), .count_valid(count_valid),
    .state(state), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic drive();
    ifc.in_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
    ifc.in_data0 = (q0.size() != 0) ? q0[0] : 10'd0;
    ifc.in_data1 = (q1.size() != 0) ? q1[0] : 10'd0;
    ifc.in_data2 = (q2.size() != 0) ? q2[0] : 10'd0;
    ifc.in_data3 = (q3.size() != 0) ? q3[0] : 10'd0;
  endtask

  function automatic logic [9:0] head_of(input int w);
    case (w)
      0: return (q0.size() != 0) ? q0[0] : 10'd0;
      1: return (q1.size() != 0) ? q1[0] : 10'd0;
      2: return (q2.size() != 0) ? q2[0] : 10'd0;
      default: return (q3.size() != 0) ? q3[0] : 10'd0;
    endcase
  endfunction

  task automatic sample(output logic [3:0] p);
    @(negedge clk);
    p = ifc.pop_in;
  endtask

  task automatic edge_apply(input logic [3:0] p);
    @(posedge clk);
    #1;
    if (p[0] && q0.size() != 0) void'(q0.pop_front());
    if (p[1] && q1.size() != 0) void'(q1.pop_front());
    if (p[2] && q2.size() != 0) void'(q2.pop_front());
    if (p[3] && q3.size() != 0) void'(q3.pop_front());
    drive();
  endtask

  task automatic clear_counters();
    init = 1'b1; edge_apply(4'b0000);
    edge_apply(4'b0000);
    init = 1'b0; edge_apply(4'b0000);
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b0; limit_low = 3'd0; limit_high = 3'd0;
    req = 1'b0; idx = 2'd0; ifc.out_almost_full = 4'b0000;
    drive();
    edge_apply(4'b0000);
    edge_apply(4'b0000);
    tests_run++; if (state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d exp 0", state); end
    tests_run++; if (ifc.pop_in !== 4'b0000) begin tests_failed++; $display("FAIL reset_pop got %b exp 0000", ifc.pop_in); end
    tests_run++; if (ifc.push_out !== 4'b0000) begin tests_failed++; $display("FAIL reset_push got %b exp 0000", ifc.push_out); end
    tests_run++; if (ifc.data_out !== 10'd0) begin tests_failed++; $display("FAIL reset_data got %h exp 000", ifc.data_out); end
    tests_run++; if (cfg_low !== 3'd1) begin tests_failed++; $display("FAIL reset_cfg_low got %0d exp 1", cfg_low); end
    tests_run++; if (cfg_high !== 3'd6) begin tests_failed++; $display("FAIL reset_cfg_high got %0d exp 6", cfg_high); end
    tests_run++; if (count_data !== 5'd0) begin tests_failed++; $display("FAIL reset_count_data got %0d exp 0", count_data); end
    tests_run++; if (count_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_count_valid got %b exp 0", count_valid); end
    tests_run++; if (idle !== 1'b0) begin tests_failed++; $display("FAIL reset_idle got %b exp 0", idle); end
  endtask

  task automatic test_init();
    reset = 1'b0; init = 1'b1; limit_low = 3'd3; limit_high = 3'd6;
    edge_apply(4'b0000);
    tests_run++; if (state !== 2'd1) begin tests_failed++; $display("FAIL init_enter got %0d exp 1", state); end
    edge_apply(4'b0000);
    tests_run++; if (cfg_low !== 3'd3 || cfg_high !== 3'd6) begin tests_failed++; $display("FAIL init_cfg36 got %0d/%0d exp 3/6", cfg_low, cfg_high); end
    limit_low = 3'd2; limit_high = 3'd7; req = 1'b1; idx = 2'd0;
    edge_apply(4'b0000);
    tests_run++; if (cfg_low !== 3'd2 || cfg_high !== 3'd7) begin tests_failed++; $display("FAIL init_cfg27 got %0d/%0d exp 2/7", cfg_low, cfg_high); end
    tests_run++; if (count_valid !== 1'b0) begin tests_failed++; $display("FAIL init_read_valid got %b exp 0", count_valid); end
    req = 1'b0; init = 1'b0;
    edge_apply(4'b0000);
    tests_run++; if (state !== 2'd2 || idle !== 1'b1) begin tests_failed++; $display("FAIL init_to_idle got state %0d idle %b exp 2/1", state, idle); end
  endtask

  task automatic test_bad_cfg();
    init = 1'b1; limit_low = 3'd5; limit_high = 3'd4;
    edge_apply(4'b0000);
    tests_run++; if (state !== 2'd1 || idle !== 1'b0) begin tests_failed++; $display("FAIL idle_to_init got state %0d idle %b exp 1/0", state, idle); end
    edge_apply(4'b0000);
    tests_run++; if (cfg_low !== 3'd2 || cfg_high !== 3'd7) begin tests_failed++; $display("FAIL cfg_hold_54 got %0d/%0d exp 2/7", cfg_low, cfg_high); end
    limit_low = 3'd4; limit_high = 3'd4;
    edge_apply(4'b0000);
    tests_run++; if (cfg_low !== 3'd2 || cfg_high !== 3'd7) begin tests_failed++; $display("FAIL cfg_hold_44 got %0d/%0d exp 2/7", cfg_low, cfg_high); end
    init = 1'b0; limit_low = 3'd2; limit_high = 3'd7;
    edge_apply(4'b0000);
  endtask

  task automatic test_rr();
    int nd = 0;
    int exp_w;
    logic [3:0] p;
    logic [9:0] w_word;
    logic had;
    for (int j = 0; j < 8; j++) begin
      q0.push_back({2'(j % 4), 8'(8'h00 + j)});
      q1.push_back({2'(j % 4), 8'(8'h10 + j)});
      q2.push_back({2'(j % 4), 8'(8'h20 + j)});
      q3.push_back({2'(j % 4), 8'(8'h30 + j)});
    end
    drive();
    for (int c = 0; c < 50 && nd < 32; c++) begin
      sample(p);
      had = 1'b0;
      w_word = 10'd0;
      if (p !== 4'b0000) begin
`ifdef FSCHED_RR_EN
        exp_w = nd % 4;
`else
        exp_w = nd / 8;
`endif
        tests_run++; if (p !== (4'b0001 << exp_w)) begin tests_failed++; $display("FAIL rr_pop_%0d got %b exp input %0d", nd, p, exp_w); end
        w_word = head_of(exp_w);
        had = 1'b1;
        nd++;
      end
      edge_apply(p);
      if (had) begin
        tests_run++;
        if (ifc.push_out !== (4'b0001 << w_word[9:8]) || ifc.data_out !== w_word) begin
          tests_failed++; $display("FAIL rr_push_%0d got %b/%h exp %b/%h", nd, ifc.push_out, ifc.data_out, 4'b0001 << w_word[9:8], w_word);
        end
      end
    end
    tests_run++; if (nd !== 32) begin tests_failed++; $display("FAIL rr_total got %0d exp 32", nd); end
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; idx = 2'(i);
      edge_apply(4'b0000);
      tests_run++; if (count_valid !== 1'b1 || count_data !== 5'd8) begin tests_failed++; $display("FAIL rr_count_%0d got %b/%0d exp 1/8", i, count_valid, count_data); end
    end
    req = 1'b0;
    edge_apply(4'b0000);
  endtask

  task automatic test_almost_full();
    logic [3:0] p;
    logic [9:0] w_word;
    int exp_seq[3];
    int nd = 0;
    logic had;
`ifdef FSCHED_RR_EN
    exp_seq = '{0, 2, 0};
`else
    exp_seq = '{0, 0, 2};
`endif
    q0.push_back(10'h1A1); q0.push_back(10'h1A2);
    q2.push_back(10'h1C1);
    q3.push_back(10'h0D1);
    ifc.out_almost_full = 4'b0010;
    drive();
    sample(p); edge_apply(p);
    sample(p);
    tests_run++; if (p !== 4'b1000) begin tests_failed++; $display("FAIL af_skip got %b exp 1000", p); end
    edge_apply(p);
    tests_run++; if (ifc.push_out !== 4'b0001 || ifc.data_out !== 10'h0D1) begin tests_failed++; $display("FAIL af_push3 got %b/%h exp 0001/0d1", ifc.push_out, ifc.data_out); end
    for (int c = 0; c < 2; c++) begin
      sample(p);
      tests_run++; if (p !== 4'b0000) begin tests_failed++; $display("FAIL af_blocked_%0d got %b exp 0000", c, p); end
      edge_apply(p);
    end
    ifc.out_almost_full = 4'b0000;
    for (int c = 0; c < 10 && nd < 3; c++) begin
      sample(p);
      had = 1'b0;
      w_word = 10'd0;
      if (p !== 4'b0000) begin
        tests_run++; if (p !== (4'b0001 << exp_seq[nd])) begin tests_failed++; $display("FAIL af_order_%0d got %b exp input %0d", nd, p, exp_seq[nd]); end
        w_word = head_of(exp_seq[nd]);
        had = 1'b1;
        nd++;
      end
      edge_apply(p);
      if (had) begin
        tests_run++; if (ifc.push_out !== 4'b0010 || ifc.data_out !== w_word) begin tests_failed++; $display("FAIL af_push_%0d got %b/%h exp 0010/%h", nd, ifc.push_out, ifc.data_out, w_word); end
      end
    end
    tests_run++; if (nd !== 3) begin tests_failed++; $display("FAIL af_total got %0d exp 3", nd); end
  endtask

  task automatic test_counter_read();
    logic [3:0] p;
    int nd = 0;
    bit done = 1'b0;
    clear_counters();
    for (int j = 0; j < 6; j++) q1.push_back({2'd2, 8'(8'h40 + j)});
    drive();
    for (int c = 0; c < 20 && !done; c++) begin
      sample(p);
      if (p !== 4'b0000) begin
        nd++;
        tests_run++; if (p !== 4'b0010) begin tests_failed++; $display("FAIL cr_pop_%0d got %b exp 0010", nd, p); end
        if (nd == 6) begin
          req = 1'b1; idx = 2'd2;
          edge_apply(p);
          tests_run++; if (count_valid !== 1'b1 || count_data !== 5'd5) begin tests_failed++; $display("FAIL cr_pre_inc got %b/%0d exp 1/5", count_valid, count_data); end
          sample(p); edge_apply(p);
          tests_run++; if (count_valid !== 1'b1 || count_data !== 5'd6) begin tests_failed++; $display("FAIL cr_post_inc got %b/%0d exp 1/6", count_valid, count_data); end
          req = 1'b0;
          edge_apply(4'b0000);
          tests_run++; if (count_valid !== 1'b0 || count_data !== 5'd0) begin tests_failed++; $display("FAIL cr_no_req got %b/%0d exp 0/0", count_valid, count_data); end
          done = 1'b1;
        end else begin
          edge_apply(p);
        end
      end else begin
        edge_apply(p);
      end
    end
    tests_run++; if (nd !== 6) begin tests_failed++; $display("FAIL cr_total got %0d exp 6", nd); end
  endtask

  task automatic test_wrap();
    logic [3:0] p;
    int nd = 0;
    clear_counters();
    for (int j = 0; j < 33; j++) q0.push_back({2'd3, 8'(j)});
    drive();
    for (int c = 0; c < 60 && nd < 33; c++) begin
      sample(p);
      if (p !== 4'b0000) nd++;
      edge_apply(p);
    end
    tests_run++; if (nd !== 33) begin tests_failed++; $display("FAIL wrap_total got %0d exp 33", nd); end
    req = 1'b1; idx = 2'd3;
    edge_apply(4'b0000);
    tests_run++; if (count_valid !== 1'b1 || count_data !== 5'd1) begin tests_failed++; $display("FAIL wrap_count3 got %b/%0d exp 1/1", count_valid, count_data); end
    idx = 2'd0;
    edge_apply(4'b0000);
    tests_run++; if (count_data !== 5'd0) begin tests_failed++; $display("FAIL wrap_count0 got %0d exp 0", count_data); end
    req = 1'b0;
    edge_apply(4'b0000);
  endtask

  task automatic test_init_priority();
    logic [3:0] p;
    logic [9:0] w_word;
    q0.push_back(10'h0E5);
    drive();
    sample(p);
    tests_run++; if (p !== 4'b0000) begin tests_failed++; $display("FAIL ip_idle_pop got %b exp 0000", p); end
    edge_apply(p);
    tests_run++; if (state !== 2'd3) begin tests_failed++; $display("FAIL ip_active got %0d exp 3", state); end
    init = 1'b1;
    sample(p);
    tests_run++; if (p !== 4'b0000) begin tests_failed++; $display("FAIL ip_init_pop got %b exp 0000", p); end
    edge_apply(p);
    tests_run++; if (state !== 2'd1 || ifc.push_out !== 4'b0000) begin tests_failed++; $display("FAIL ip_to_init got %0d/%b exp 1/0000", state, ifc.push_out); end
    init = 1'b0;
    edge_apply(4'b0000);
    sample(p); edge_apply(p);
    sample(p);
    tests_run++; if (p !== 4'b0001) begin tests_failed++; $display("FAIL ip_resume_pop got %b exp 0001", p); end
    w_word = head_of(0);
    edge_apply(p);
    tests_run++; if (ifc.push_out !== 4'b0001 || ifc.data_out !== w_word) begin tests_failed++; $display("FAIL ip_resume_push got %b/%h exp 0001/%h", ifc.push_out, ifc.data_out, w_word); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_bad_cfg();
    test_rr();
    test_almost_full();
    test_counter_read();
    test_wrap();
    test_init_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
